capture_readout_ctrl: RTL and testbench

CAPTURE_READOUT_CTRL -- requirements
Module: capture_readout_ctrl

---
 rtl/readout_ctrl_pkg.sv | 27 ++
 rtl/cycle_counter.sv | 36 +++
 rtl/capture_readout_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_capture_readout_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_ctrl_pkg.sv
// ============================================================================
// Module      : readout_ctrl_pkg
// Description : Shared state encoding and constants for the capture readout
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package readout_ctrl_pkg;

    localparam int c_fifo_width_default = 36;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } readout_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_counter.sv
// ============================================================================
// Module      : cycle_counter
// Description : Loadable down-counter with terminal-count flag (count == 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cycle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/capture_readout_ctrl.sv
// ============================================================================
// Module      : capture_readout_ctrl
// Description : Starts a capture, waits for the capture FIFO flush, then reads
//               a requested number of words out to a ready/valid consumer.
//               Optional idle-read timeout enabled by READOUT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_readout_ctrl
    import readout_ctrl_pkg::*;
#(
    parameter int FIFO_WIDTH     = c_fifo_width_default,
    parameter int NWORDS_WIDTH   = 10,
    parameter int FLUSH_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_start,
    input  logic                    cmd_abort,
    input  logic [NWORDS_WIDTH-1:0] cmd_nwords,
    output logic                    start_pulse,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0]   fifo_q,
    output logic [FIFO_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [NWORDS_WIDTH-1:0] word_count
);

`ifdef READOUT_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(max_int(FLUSH_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [c_cnt_w-1:0] c_timeout_load = c_cnt_w'(TIMEOUT_CYCLES - 1);
`else
    localparam int c_cnt_w = $clog2(FLUSH_CYCLES + 1);
`endif
    localparam logic [c_cnt_w-1:0] c_flush_load = c_cnt_w'(FLUSH_CYCLES - 1);

    if ((FLUSH_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("FLUSH_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    readout_state_e              r_state;
    logic [NWORDS_WIDTH-1:0]     r_nwords;
    logic [NWORDS_WIDTH-1:0]     r_rd_issued;
    logic [NWORDS_WIDTH-1:0]     r_word_count;
    logic                        r_rd_pending;
    logic [FIFO_WIDTH-1:0]       r_dout;
    logic                        r_dout_valid;
    logic                        r_start_pulse;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_timeout;

    logic                        w_rd_en;
    logic                        w_handshake;
    logic                        w_timeout_hit;
    logic                        w_cnt_load;
    logic [c_cnt_w-1:0]          w_cnt_load_value;
    logic                        w_cnt_enable;
    logic                        w_cnt_tc;

    // Read only when the output slot will be free by the time the word lands.
    assign w_rd_en = (r_state == ST_READ) && !cmd_abort && !fifo_empty &&
                     !r_rd_pending && (!r_dout_valid || dout_ready) &&
                     (r_rd_issued < r_nwords);

    assign w_handshake = r_dout_valid && dout_ready;

    always_comb begin
        w_cnt_load       = 1'b0;
        w_cnt_load_value = c_flush_load;
        w_cnt_enable     = 1'b0;
        w_timeout_hit    = 1'b0;
        if (r_state == ST_ARM) begin
            w_cnt_load = 1'b1;
        end else if (r_state == ST_FLUSH) begin
            w_cnt_enable = 1'b1;
        end
`ifdef READOUT_TIMEOUT_EN
        // The same counter is reused as the idle-read watchdog once in READ.
        if ((r_state == ST_FLUSH) && w_cnt_tc) begin
            w_cnt_load       = 1'b1;
            w_cnt_load_value = c_timeout_load;
        end else if (r_state == ST_READ) begin
            if (w_rd_en) begin
                w_cnt_load       = 1'b1;
                w_cnt_load_value = c_timeout_load;
            end else begin
                w_cnt_enable = 1'b1;
            end
        end
        w_timeout_hit = (r_state == ST_READ) && !w_rd_en && w_cnt_tc;
`endif
    end

    cycle_counter #(
        .WIDTH (c_cnt_w)
    ) u_cycle_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_load_value),
        .i_enable     (w_cnt_enable),
        .o_tc         (w_cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_nwords      <= '0;
            r_rd_issued   <= '0;
            r_word_count  <= '0;
            r_rd_pending  <= 1'b0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_start_pulse <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_start_pulse <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            if (cmd_abort && (r_state != ST_IDLE)) begin
                r_state      <= ST_IDLE;
                r_busy       <= 1'b0;
                r_dout_valid <= 1'b0;
                r_rd_pending <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_start && !cmd_abort) begin
                            r_state       <= ST_ARM;
                            r_busy        <= 1'b1;
                            r_start_pulse <= 1'b1;
                            r_nwords      <= cmd_nwords;
                            r_rd_issued   <= '0;
                            r_word_count  <= '0;
                        end
                    end
                    ST_ARM: begin
                        r_state <= ST_FLUSH;
                    end
                    ST_FLUSH: begin
                        if (w_cnt_tc) begin
                            if (r_nwords == '0) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_READ;
                            end
                        end
                    end
                    ST_READ: begin
                        r_rd_pending <= w_rd_en;
                        if (w_rd_en) begin
                            r_rd_issued <= r_rd_issued + 1'b1;
                        end
                        // fifo_q is valid the cycle after the read strobe.
                        if (r_rd_pending) begin
                            r_dout       <= fifo_q;
                            r_dout_valid <= 1'b1;
                        end else if (w_handshake) begin
                            r_dout_valid <= 1'b0;
                        end
                        if (w_handshake) begin
                            r_word_count <= r_word_count + 1'b1;
                        end
                        if ((r_word_count == r_nwords) && !r_dout_valid) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (w_timeout_hit) begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_timeout    <= 1'b1;
                            r_dout_valid <= 1'b0;
                            r_rd_pending <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign start_pulse = r_start_pulse;
    assign fifo_rd_en  = w_rd_en;
    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign word_count  = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_capture_readout_ctrl.sv
// ============================================================================
// Module      : tb_capture_readout_ctrl
// Description : Self-checking bench for capture_readout_ctrl with a FIFO model
//               and an expected-word scoreboard (READOUT_TIMEOUT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_capture_readout_ctrl;

    localparam int FW = 36;
    localparam int NW = 10;
    localparam int FLUSH = 16;
`ifdef READOUT_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 65535;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [NW-1:0] cmd_nwords = '0;
    logic          start_pulse;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [FW-1:0] fifo_q = '0;
    logic [FW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [NW-1:0] word_count;

    always #5 clk = ~clk;

    capture_readout_ctrl #(
        .FIFO_WIDTH     (FW),
        .NWORDS_WIDTH   (NW),
        .FLUSH_CYCLES   (FLUSH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_abort   (cmd_abort),
        .cmd_nwords  (cmd_nwords),
        .start_pulse (start_pulse),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_q      (fifo_q),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .word_count  (word_count)
    );

    // FIFO model: the stimulus side owns writes, this process owns reads.
    logic [FW-1:0] fifo_mem [64];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          fifo_clr = 1'b0;
    int            rd_cnt = 0;
    int            rd_empty_cnt = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (fifo_empty) begin
                rd_empty_cnt <= rd_empty_cnt + 1;
            end else begin
                fifo_q <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
        end else if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end
    end

    // Output monitor, sampled on the falling edge.
    int            cyc = 0;
    int            sp_cnt = 0, done_cnt = 0, tmo_cnt = 0;
    int            sp_cyc = 0, done_cyc = 0, tmo_cyc = 0;
    int            stab_err = 0;
    logic          prev_hold = 1'b0;
    logic [FW-1:0] prev_dout = '0;
    logic [FW-1:0] obs_mem [64];
    int            obs_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start_pulse) begin sp_cnt <= sp_cnt + 1; sp_cyc <= cyc; end
        if (done)        begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
        if (timeout)     begin tmo_cnt <= tmo_cnt + 1; tmo_cyc <= cyc; end
        if (prev_hold && busy && (!dout_valid || dout !== prev_dout)) stab_err <= stab_err + 1;
        prev_hold <= dout_valid && !dout_ready;
        prev_dout <= dout;
        if (dout_valid && dout_ready) begin
            obs_mem[obs_wr] <= dout;
            obs_wr          <= obs_wr + 1;
        end
    end

    int            n_checks = 0;
    int            n_errors = 0;
    logic [FW-1:0] exp_q [$];
    int            obs_rd = 0;
    int            s_cyc = 0;
    int            sp0, rd0, done0, tmo0, stab0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        sp0 = sp_cnt; rd0 = rd_cnt; done0 = done_cnt; tmo0 = tmo_cnt; stab0 = stab_err;
    endtask

    task automatic load_fifo(input int n);
        logic [FW-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = {4'(i), 32'($urandom)};
            fifo_mem[wr_ptr] = v;
            wr_ptr++;
            exp_q.push_back(v);
        end
    endtask

    task automatic clear_fifo();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        exp_q.delete();
        obs_rd = obs_wr;
    endtask

    task automatic start(input int n);
        cmd_nwords = NW'(n);
        cmd_start  = 1'b1;
        s_cyc      = cyc;
        tick();
        cmd_start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_wc(input string tag, input int target, input int budget);
        int n = 0;
        while (int'(word_count) != target && n < budget) begin tick(); n++; end
        chk(tag, 64'(word_count), 64'(target));
    endtask

    task automatic compare_words(input string tag, input int n);
        logic [FW-1:0] e;
        chk({tag, "_count"}, 64'(obs_wr - obs_rd), 64'(n));
        for (int i = 0; i < n && obs_rd < obs_wr && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 64'(obs_mem[obs_rd]), 64'(e));
            obs_rd++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_start_pulse"}, 64'(start_pulse), 64'd0);
        chk({tag, "_fifo_rd_en"},  64'(fifo_rd_en), 64'd0);
        chk({tag, "_dout_valid"},  64'(dout_valid), 64'd0);
        chk({tag, "_busy"},        64'(busy), 64'd0);
        chk({tag, "_done"},        64'(done), 64'd0);
        chk({tag, "_timeout"},     64'(timeout), 64'd0);
        chk({tag, "_dout"},        64'(dout), 64'd0);
        chk({tag, "_word_count"},  64'(word_count), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Four words straight through with the consumer always ready.
        snap();
        dout_ready = 1'b1;
        load_fifo(4);
        start(4);
        wait_idle("t1_idle", 200);
        chk("t1_start_pulses", 64'(sp_cnt - sp0), 64'd1);
        chk("t1_reads", 64'(rd_cnt - rd0), 64'd4);
        chk("t1_done_cycles", 64'(done_cnt - done0), 64'd1);
        chk("t1_word_count", 64'(word_count), 64'd4);
        compare_words("t1", 4);

        // Backpressure for five cycles mid-stream.
        snap();
        load_fifo(3);
        start(3);
        wait_wc("t2_wc1", 1, 200);
        dout_ready = 1'b0;
        repeat (5) tick();
        dout_ready = 1'b1;
        wait_idle("t2_idle", 200);
        chk("t2_stable", 64'(stab_err - stab0), 64'd0);
        chk("t2_reads", 64'(rd_cnt - rd0), 64'd3);
        chk("t2_done_cycles", 64'(done_cnt - done0), 64'd1);
        chk("t2_word_count", 64'(word_count), 64'd3);
        compare_words("t2", 3);

        // Zero-word request: flush only.
        snap();
        start(0);
        wait_idle("t3_idle", 200);
        chk("t3_start_pulses", 64'(sp_cnt - sp0), 64'd1);
        chk("t3_start_latency", 64'(sp_cyc - s_cyc), 64'd1);
        chk("t3_done_latency", 64'(done_cyc - s_cyc), 64'(FLUSH + 2));
        chk("t3_done_cycles", 64'(done_cnt - done0), 64'd1);
        chk("t3_reads", 64'(rd_cnt - rd0), 64'd0);

        // Abort after two of five words.
        snap();
        load_fifo(5);
        start(5);
        wait_wc("t4_wc2", 2, 200);
        cmd_abort  = 1'b1;
        dout_ready = 1'b0;
        tick();
        cmd_abort  = 1'b0;
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_dout_valid", 64'(dout_valid), 64'd0);
        chk("t4_word_count", 64'(word_count), 64'd2);
        repeat (3) tick();
        chk("t4_dout_valid_later", 64'(dout_valid), 64'd0);
        chk("t4_done_cycles", 64'(done_cnt - done0), 64'd0);
        compare_words("t4", 2);
        dout_ready = 1'b1;
        clear_fifo();

        // Empty FIFO while in READ.
        snap();
        start(3);
`ifdef READOUT_TIMEOUT_EN
        wait_idle("t5_idle", 200);
        chk("t5_timeout_cycles", 64'(tmo_cnt - tmo0), 64'd1);
        chk("t5_timeout_latency", 64'(tmo_cyc - s_cyc), 64'(FLUSH + 2 + TMO));
        chk("t5_done_cycles", 64'(done_cnt - done0), 64'd0);
`else
        repeat (FLUSH + 60) tick();
        chk("t5_still_busy", 64'(busy), 64'd1);
        chk("t5_timeout_cycles", 64'(tmo_cnt - tmo0), 64'd0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("t5_abort_idle", 64'(busy), 64'd0);
        chk("t5_done_cycles", 64'(done_cnt - done0), 64'd0);
`endif
        chk("t5_reads", 64'(rd_cnt - rd0), 64'd0);

        // Second start while busy, then reset during READ.
        snap();
        dout_ready = 1'b0;
        load_fifo(4);
        start(4);
        repeat (3) tick();
        start(7);
        begin
            int n = 0;
            while (!dout_valid && n < 200) begin tick(); n++; end
            chk("t6_reached_read", 64'(dout_valid), 64'd1);
        end
        repeat (4) tick();
        chk("t6_start_pulses", 64'(sp_cnt - sp0), 64'd1);
        chk("t6_reads_held", 64'(rd_cnt - rd0), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_outputs_zero("t6_after_rst");
        chk("t6_done_cycles", 64'(done_cnt - done0), 64'd0);
        dout_ready = 1'b1;
        clear_fifo();

        chk("rd_while_empty", 64'(rd_empty_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
